// File: rtl/nom_sweeper.sv
// Sequencer that walks the variant table indices 0..15, dwells on each, samples y,
// and accumulates the sum, maximum and index of the maximum over the sweep.
module nom_sweeper #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hold,
    output logic [3:0] nom,
    input  logic [3:0] y,
    output logic       busy,
    output logic       done,
    output logic [3:0] cur_y,
    output logic [7:0] sum,
    output logic [3:0] max_val,
    output logic [3:0] max_idx
);

    // state  | meaning
    // IDLE   | waiting for start, nom parked at 0, results held
    // DRIVE  | nom held while the dwell counter runs
    // SAMPLE | one cycle: capture y, update sum/max, advance nom
    // DONE   | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

    state_t      state_q,   state_d;
    logic [15:0] cnt_q,     cnt_d;
    logic [3:0]  nom_q,     nom_d;
    logic        busy_q,    busy_d;
    logic        done_q,    done_d;
    logic [3:0]  cur_y_q,   cur_y_d;
    logic [7:0]  sum_q,     sum_d;
    logic [3:0]  max_val_q, max_val_d;
    logic [3:0]  max_idx_q, max_idx_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        nom_d     = nom_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cur_y_d   = cur_y_q;
        sum_d     = sum_q;
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        case (state_q)
            IDLE: begin
                nom_d  = 4'h0;
                busy_d = 1'b0;
                if (start) begin
                    state_d   = DRIVE;
                    cnt_d     = 16'd0;
                    busy_d    = 1'b1;
                    cur_y_d   = 4'h0;
                    sum_d     = 8'h00;
                    max_val_d = 4'h0;
                    max_idx_d = 4'h0;
                end
            end
            DRIVE: begin
                if (!hold) begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = SAMPLE;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            SAMPLE: begin
                cur_y_d = y;
                sum_d   = sum_q + {4'h0, y};
                // Strict compare so ties keep the lowest index.
                if (y > max_val_q) begin
                    max_val_d = y;
                    max_idx_d = nom_q;
                end
                cnt_d = 16'd0;
                if (nom_q == 4'hF) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    nom_d   = nom_q + 4'h1;
                    state_d = DRIVE;
                end
            end
            DONE: begin
                state_d = IDLE;
                nom_d   = 4'h0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            nom_q     <= 4'h0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cur_y_q   <= 4'h0;
            sum_q     <= 8'h00;
            max_val_q <= 4'h0;
            max_idx_q <= 4'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nom_q     <= nom_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cur_y_q   <= cur_y_d;
            sum_q     <= sum_d;
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
        end
    end

    assign nom     = nom_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cur_y   = cur_y_q;
    assign sum     = sum_q;
    assign max_val = max_val_q;
    assign max_idx = max_idx_q;

endmodule

// File: tb/tb_nom_sweeper.sv
// Scoreboard bench for nom_sweeper: a DWELL=4 instance and a DWELL=1 instance,
// each driving its own combinational table model.
module tb_nom_sweeper;

    typedef struct {
        int done_edge;
        int sum;
        int mx;
        int idx;
        int cy;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0, start = 1'b0, hold = 1'b0, start1 = 1'b0;
    logic [3:0] nom, y, cur_y, max_val, max_idx;
    logic [7:0] sum;
    logic       busy, done;
    logic [3:0] nom1, y1, cur_y1, max_val1, max_idx1;
    logic [7:0] sum1;
    logic       busy1, done1;

    logic [3:0] tbl  [16];
    logic [3:0] ptab [16];
    assign y  = tbl[nom];
    assign y1 = ptab[nom1];

    int   edge_n = 0;
    int   checks = 0, errors = 0;
    exp_t sb[$], sb1[$];
    exp_t em, em1;

    always @(posedge clk) edge_n <= edge_n + 1;

    nom_sweeper #(.DWELL(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold), .nom(nom), .y(y),
        .busy(busy), .done(done), .cur_y(cur_y), .sum(sum),
        .max_val(max_val), .max_idx(max_idx)
    );

    nom_sweeper #(.DWELL(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .hold(1'b0), .nom(nom1), .y(y1),
        .busy(busy1), .done(done1), .cur_y(cur_y1), .sum(sum1),
        .max_val(max_val1), .max_idx(max_idx1)
    );

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endfunction

    // Reference: plain arithmetic over the table contents.
    function automatic exp_t model(input int which);
        exp_t e;
        int   v;
        e.sum = 0; e.mx = 0; e.idx = 0; e.cy = 0; e.done_edge = -1;
        for (int i = 0; i < 16; i++) begin
            v = (which == 0) ? int'(tbl[i]) : int'(ptab[i]);
            e.sum += v;
            if (v > e.mx) begin
                e.mx  = v;
                e.idx = i;
            end
            e.cy = v;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done=1 required done=0 (edge %0d)", edge_n);
            end else begin
                em = sb.pop_front();
                if (em.done_edge >= 0) chk("done_edge", edge_n, em.done_edge);
                chk("sum", int'(sum), em.sum);
                chk("max_val", int'(max_val), em.mx);
                chk("max_idx", int'(max_idx), em.idx);
                chk("cur_y", int'(cur_y), em.cy);
                chk("busy_at_done", int'(busy), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (done1) begin
            if (sb1.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done1: got done=1 required done=0 (edge %0d)", edge_n);
            end else begin
                em1 = sb1.pop_front();
                chk("d1_done_edge", edge_n, em1.done_edge);
                chk("d1_sum", int'(sum1), em1.sum);
                chk("d1_max_val", int'(max_val1), em1.mx);
                chk("d1_max_idx", int'(max_idx1), em1.idx);
                chk("d1_cur_y", int'(cur_y1), em1.cy);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_nom"}, int'(nom), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_cur_y"}, int'(cur_y), 0);
        chk({tag, "_sum"}, int'(sum), 0);
        chk({tag, "_max_val"}, int'(max_val), 0);
        chk({tag, "_max_idx"}, int'(max_idx), 0);
    endtask

    // mode 0 plain, 1 hold at nom=3, 2 random hold, 3 start while busy, 4 reset at nom=7
    task automatic sweep(input int mode);
        exp_t e;
        int   s;
        e = model(0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        s = edge_n;
        e.done_edge = (mode == 2) ? -1 : s + 80 + ((mode == 1) ? 10 : 0);
        sb.push_back(e);
        for (int k = 0; k < 400; k++) begin
            if (sb.size() == 0) break;
            case (mode)
                0, 3: begin
                    if (k < 80) begin
                        chk("nom_step", int'(nom), k / 5);
                        chk("busy_sweep", int'(busy), 1);
                    end
                    if (mode == 3) start = (k == 10);
                end
                1: begin
                    hold = (k >= 16 && k < 26);
                    if (k == 16) chk("nom_at_hold", int'(nom), 3);
                end
                2: hold = ($urandom_range(0, 2) == 0);
                4: begin
                    if (k == 35) begin
                        chk("nom_at_rst", int'(nom), 7);
                        chk("sum_before_rst_nonzero", int'(sum != 8'h00), 1);
                        rst = 1'b1;
                        @(posedge clk); #1 rst = 1'b0;
                        check_reset_vals("midrst");
                        sb.delete();
                        break;
                    end
                end
                default: ;
            endcase
            @(posedge clk); #1;
        end
        hold  = 1'b0;
        start = 1'b0;
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL sweep_timeout: got no done required done within budget (mode %0d)", mode);
            sb.delete();
        end
    endtask

    task automatic sweep1();
        exp_t e;
        int   s;
        e = model(1);
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        s = edge_n;
        e.done_edge = s + 32;
        sb1.push_back(e);
        for (int k = 0; k < 100; k++) begin
            if (sb1.size() == 0) break;
            @(posedge clk); #1;
        end
        if (sb1.size() != 0) begin
            checks++; errors++;
            $display("FAIL sweep1_timeout: got no done required done within budget");
            sb1.delete();
        end
    endtask

    initial begin
        logic [3:0] prod [16];
        prod = '{4'h7, 4'hA, 4'h3, 4'hC, 4'h1, 4'h9, 4'hE, 4'h4,
                 4'hF, 4'h2, 4'hB, 4'h8, 4'hD, 4'h5, 4'h3, 4'h6};
        for (int i = 0; i < 16; i++) begin
            tbl[i]  = prod[i];
            ptab[i] = prod[i];
        end

        rst = 1'b1; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_reset_vals("reset");
        end
        rst = 1'b0; start = 1'b0;

        sweep(0);
        sweep(1);
        sweep(3);
        sweep(4);
        sweep(0);

        for (int i = 0; i < 16; i++) tbl[i] = 4'h5;
        sweep(0);
        for (int i = 0; i < 16; i++) tbl[i] = 4'h0;
        sweep(0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) tbl[i] = 4'($urandom_range(0, 15));
            sweep(2);
        end

        sweep1();
        sweep1();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
